// File: rtl/mic1_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mic1_mem_ctrl
// Purpose  : MIC-1 memory controller; data and fetch requests share one bus.
// Config   : MIC1_MEM_TIMEOUT_EN adds a 255-cycle bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mic1_mem_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        fetch_req,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] pc,
  output logic [31:0] ram_data,
  output logic [31:0] rom_data,
  output logic        rd_done,
  output logic        wr_done,
  output logic        fetch_done,
  output logic        busy,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_RD = 2'd1,
    DATA_WR = 2'd2,
    FETCH   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_d_valid;
  logic        r_d_write;
  logic [29:0] r_d_mar;
  logic [31:0] r_d_mdr;
  logic        r_f_valid;
  logic [31:0] r_f_pc;

  logic        w_tmo;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [7:0]  w_lane;
  logic        w_data_clr;
  logic        w_fetch_clr;
  logic        w_data_req;
  logic        w_data_drop;
  logic        w_fetch_drop;
  logic        w_unused_ok;

  // Word addressing discards the top two MAR bits.
  assign w_unused_ok = &{1'b0, mar[31:30]};

`ifdef MIC1_MEM_TIMEOUT_EN
  localparam logic [7:0] C_TMO_LAST = 8'd254;
  logic [7:0] r_tmo_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == IDLE || w_ack) begin
      r_tmo_cnt <= 8'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // Fires during the 255th bus cycle without an acknowledge.
  assign w_tmo   = (r_state != IDLE) && !mem_ack && (r_tmo_cnt == C_TMO_LAST);
  assign w_rdata = w_tmo ? 32'hDEADBEEF : mem_rdata;
`else
  assign w_tmo   = 1'b0;
  assign w_rdata = mem_rdata;
`endif

  assign w_ack        = mem_ack | w_tmo;
  assign w_data_clr   = w_ack && (r_state == DATA_RD || r_state == DATA_WR);
  assign w_fetch_clr  = w_ack && (r_state == FETCH);
  assign w_data_req   = rd_req | wr_req;
  // An occupied slot still accepts a request on the edge it is being freed.
  assign w_data_drop  = w_data_req && r_d_valid && !w_data_clr;
  assign w_fetch_drop = fetch_req && r_f_valid && !w_fetch_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_d_valid) begin
          w_next = r_d_write ? DATA_WR : DATA_RD;
        end else if (r_f_valid) begin
          w_next = FETCH;
        end
      end
      DATA_RD: begin
        mem_addr  = {r_d_mar, 2'b00};
        mem_wdata = r_d_mdr;
        mem_re    = 1'b1;
        if (w_ack) w_next = IDLE;
      end
      DATA_WR: begin
        mem_addr  = {r_d_mar, 2'b00};
        mem_wdata = r_d_mdr;
        mem_we    = 1'b1;
        if (w_ack) w_next = IDLE;
      end
      FETCH: begin
        mem_addr = {r_f_pc[31:2], 2'b00};
        mem_re   = 1'b1;
        if (w_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_d_mar   <= 30'd0;
      r_d_mdr   <= 32'd0;
      r_f_valid <= 1'b0;
      r_f_pc    <= 32'd0;
      err       <= 1'b0;
    end else begin
      if (w_data_req && !w_data_drop) begin
        r_d_valid <= 1'b1;
        r_d_write <= wr_req;
        r_d_mar   <= mar[29:0];
        r_d_mdr   <= mdr;
      end else if (w_data_clr) begin
        r_d_valid <= 1'b0;
      end
      if (fetch_req && !w_fetch_drop) begin
        r_f_valid <= 1'b1;
        r_f_pc    <= pc;
      end else if (w_fetch_clr) begin
        r_f_valid <= 1'b0;
      end
      if (w_data_drop || w_fetch_drop || (rd_req && wr_req) || w_tmo) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_lane = w_rdata[7:0];
    case (r_f_pc[1:0])
      2'd0:    w_lane = w_rdata[7:0];
      2'd1:    w_lane = w_rdata[15:8];
      2'd2:    w_lane = w_rdata[23:16];
      default: w_lane = w_rdata[31:24];
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_data   <= 32'd0;
      rom_data   <= 32'd0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      rd_done    <= w_ack && (r_state == DATA_RD);
      wr_done    <= w_ack && (r_state == DATA_WR);
      fetch_done <= w_fetch_clr;
      if (w_ack && r_state == DATA_RD) ram_data <= w_rdata;
      if (w_fetch_clr) rom_data <= {24'd0, w_lane};
    end
  end

  assign busy = r_d_valid | r_f_valid | (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mic1_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic1_mem_ctrl
// Purpose  : Directed vector table plus corner sequences for mic1_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic1_mem_ctrl;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_FE = 2;
  localparam int NV   = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0, fetch_req = 1'b0;
  logic [31:0] mar = 32'd0, mdr = 32'd0, pc = 32'd0;
  logic [31:0] ram_data, rom_data;
  logic        rd_done, wr_done, fetch_done, busy, err;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          kind;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_ram;
    logic [31:0] exp_rom;
  } vec_t;

  vec_t vecs[NV];

  mic1_mem_ctrl dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar(mar), .mdr(mdr), .pc(pc),
    .ram_data(ram_data), .rom_data(rom_data),
    .rd_done(rd_done), .wr_done(wr_done), .fetch_done(fetch_done),
    .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until a bus cycle is visible; cyc counts cycles already elapsed.
  task automatic wait_bus(inout int cyc);
    while (!(mem_re || mem_we) && cyc < 16) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc;
    v = vecs[i];
    mar = v.mar; mdr = v.mdr; pc = v.pc;
    rd_req    = (v.kind == K_RD);
    wr_req    = (v.kind == K_WR);
    fetch_req = (v.kind == K_FE);
    step();
    rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
    cyc = 1;
    wait_bus(cyc);
    chk($sformatf("v%0d_latency", i), cyc, 32'd2);
    chk($sformatf("v%0d_addr", i), mem_addr, v.exp_addr);
    chk($sformatf("v%0d_we_re", i), {30'd0, mem_we, mem_re},
        (v.kind == K_WR) ? 32'd2 : 32'd1);
    if (v.kind == K_WR) chk($sformatf("v%0d_wdata", i), mem_wdata, v.mdr);
    chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = v.rdata;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
    chk($sformatf("v%0d_done", i), {29'd0, rd_done, wr_done, fetch_done},
        (v.kind == K_RD) ? 32'd4 : (v.kind == K_WR) ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_ram", i), ram_data, v.exp_ram);
    chk($sformatf("v%0d_rom", i), rom_data, v.exp_rom);
    chk($sformatf("v%0d_bus_idle", i), {30'd0, mem_we, mem_re}, 32'd0);
    step();
    chk($sformatf("v%0d_done_clr", i), {29'd0, rd_done, wr_done, fetch_done}, 32'd0);
    chk($sformatf("v%0d_busy_clr", i), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_err", i), {31'd0, err}, 32'd0);
  endtask

  initial begin
    int cyc;
    int n_we;
    int n_done;

    vecs[0] = '{K_RD, 32'h00000010, 32'h0,        32'h0,        32'hCAFEBABE, 32'h00000040, 32'hCAFEBABE, 32'h00000000};
    vecs[1] = '{K_FE, 32'h0,        32'h0,        32'h00000103, 32'h11223344, 32'h00000100, 32'hCAFEBABE, 32'h00000011};
    vecs[2] = '{K_WR, 32'h00000002, 32'h55AA55AA, 32'h0,        32'h0BADF00D, 32'h00000008, 32'hCAFEBABE, 32'h00000011};
    vecs[3] = '{K_FE, 32'h0,        32'h0,        32'h00000200, 32'h11223344, 32'h00000200, 32'hCAFEBABE, 32'h00000044};
    vecs[4] = '{K_RD, 32'hC0000001, 32'h0,        32'h0,        32'h12345678, 32'h00000004, 32'h12345678, 32'h00000044};
    vecs[5] = '{K_FE, 32'h0,        32'h0,        32'h00000FF1, 32'hA1B2C3D4, 32'h00000FF0, 32'h12345678, 32'h000000C3};
    vecs[6] = '{K_FE, 32'h0,        32'h0,        32'h00000FF2, 32'hA1B2C3D4, 32'h00000FF0, 32'h12345678, 32'h000000B2};
    vecs[7] = '{K_WR, 32'hFFFFFFFF, 32'h87654321, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345678, 32'h000000B2};
    vecs[8] = '{K_RD, 32'h3FFFFFFF, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFC, 32'h00000001, 32'h000000B2};

    // Reset state, checked while reset is still asserted.
    #3;
    chk("rst_ram", ram_data, 32'd0);
    chk("rst_rom", rom_data, 32'd0);
    chk("rst_flags", {27'd0, rd_done, wr_done, fetch_done, busy, err}, 32'd0);
    chk("rst_bus", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Read and fetch together: data wins, fetch follows.
    mar = 32'h20; pc = 32'h301; rd_req = 1'b1; fetch_req = 1'b1;
    step();
    rd_req = 1'b0; fetch_req = 1'b0;
    cyc = 1; wait_bus(cyc);
    chk("prio_first_addr", mem_addr, 32'h80);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
    step();
    mem_ack = 1'b0;
    chk("prio_rd_done", {30'd0, rd_done, fetch_done}, 32'd2);
    chk("prio_ram", ram_data, 32'hAAAA5555);
    cyc = 0; wait_bus(cyc);
    chk("prio_fetch_addr", mem_addr, 32'h300);
    chk("prio_fetch_re", {30'd0, mem_re, mem_we}, 32'd2);
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    step();
    mem_ack = 1'b0;
    chk("prio_fetch_done", {30'd0, rd_done, fetch_done}, 32'd1);
    chk("prio_rom", rom_data, 32'h33);
    chk("prio_err", {31'd0, err}, 32'd0);
    step();

    // New read on the very edge its slot frees is accepted without error.
    mar = 32'h5; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    cyc = 1; wait_bus(cyc);
    mem_ack = 1'b1; mem_rdata = 32'h01010101; mar = 32'h6; rd_req = 1'b1;
    step();
    mem_ack = 1'b0; rd_req = 1'b0;
    chk("b2b_done1", {31'd0, rd_done}, 32'd1);
    chk("b2b_ram1", ram_data, 32'h01010101);
    cyc = 0; wait_bus(cyc);
    chk("b2b_addr2", mem_addr, 32'h18);
    mem_ack = 1'b1; mem_rdata = 32'h02020202;
    step();
    mem_ack = 1'b0;
    chk("b2b_done2", {31'd0, rd_done}, 32'd1);
    chk("b2b_ram2", ram_data, 32'h02020202);
    chk("b2b_err", {31'd0, err}, 32'd0);
    step();

    // Read and write together become a write and flag an error.
    do_reset();
    mar = 32'h7; mdr = 32'hABCD0123; rd_req = 1'b1; wr_req = 1'b1;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    chk("rdwr_err", {31'd0, err}, 32'd1);
    cyc = 1; wait_bus(cyc);
    chk("rdwr_bus", {30'd0, mem_we, mem_re}, 32'd2);
    chk("rdwr_addr", mem_addr, 32'h1C);
    chk("rdwr_wdata", mem_wdata, 32'hABCD0123);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rdwr_done", {30'd0, rd_done, wr_done}, 32'd1);
    chk("rdwr_ram", ram_data, 32'd0);

    // Second write while the first is pending is dropped.
    do_reset();
    mar = 32'h2; mdr = 32'h55AA55AA; wr_req = 1'b1;
    step();
    mar = 32'h3; mdr = 32'h11111111;
    step();
    wr_req = 1'b0;
    n_we = 0; n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_done) n_done++;
      if (mem_we) begin
        n_we++;
        chk("drop_addr", mem_addr, 32'h8);
        chk("drop_wdata", mem_wdata, 32'h55AA55AA);
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
      step();
    end
    mem_ack = 1'b0;
    chk("drop_we_count", n_we, 32'd1);
    chk("drop_done_count", n_done, 32'd1);
    chk("drop_err", {31'd0, err}, 32'd1);
    step();
    step();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of a read abandons it.
    do_reset();
    mar = 32'h9; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    cyc = 1; wait_bus(cyc);
    chk("abort_in_bus", {31'd0, mem_re}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_re", {31'd0, mem_re}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_done) n_done++;
    end
    mem_ack = 1'b0;
    chk("abort_no_done", n_done, 32'd0);
    chk("abort_ram", ram_data, 32'd0);

`ifdef MIC1_MEM_TIMEOUT_EN
    do_reset();
    mar = 32'h4; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_we = 0;
    for (int i = 0; i < 400 && !rd_done; i++) begin
      if (mem_re) n_we++;
      step();
    end
    chk("tmo_bus_cycles", n_we, 32'd255);
    chk("tmo_done", {31'd0, rd_done}, 32'd1);
    chk("tmo_ram", ram_data, 32'hDEADBEEF);
    chk("tmo_err", {31'd0, err}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mic1_mem_ctrl.md
MIC1_MEM_CTRL -- requirements
Module: mic1_mem_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports rd_req / wr_req / fetch_req, input, 1 each, single-cycle requests from the datapath (data read, data write, instruction fetch).
REQ-004 SHALL have ports mar, mdr, pc, input, 32 each: word address, write data, byte address.
REQ-005 SHALL have port ram_data, output, 32: registered data-read result toward the MDR.
REQ-006 SHALL have port rom_data, output, 32: registered fetch result toward the MBR, byte in [7:0], [31:8] zero.
REQ-007 SHALL have ports rd_done, wr_done, fetch_done, output, 1 each: one-cycle completion pulses.
REQ-008 SHALL have ports busy, output, 1 (any channel pending or active), and err, output, 1 (sticky error flag).
REQ-009 SHALL have ports mem_addr (output, 32), mem_wdata (output, 32), mem_re (output, 1), mem_we (output, 1), mem_rdata (input, 32), mem_ack (input, 1): single shared memory bus.

Function
REQ-010 SHALL implement FSM states IDLE, DATA_RD, DATA_WR, FETCH.
REQ-011 SHALL latch each request into a per-channel pending slot (data slot holds kind, mar, mdr; fetch slot holds pc) on the edge where it is sampled high.
REQ-012 In IDLE with a pending slot, SHALL move next edge to DATA_RD/DATA_WR if data pending, else FETCH; data SHALL beat fetch when both pending.
REQ-013 In DATA_RD/DATA_WR, SHALL drive mem_addr = {mar[29:0],2'b00}, mem_re/mem_we respectively, mem_wdata = latched mdr; hold all stable until mem_ack sampled high.
REQ-014 In FETCH, SHALL drive mem_addr = {pc[31:2],2'b00}, mem_re = 1.
REQ-015 On the edge mem_ack is sampled high, SHALL clear the served slot, return to IDLE, and register: ram_data = mem_rdata (read), rom_data = {24'b0, mem_rdata[8*pc[1:0]+7 : 8*pc[1:0]]} (fetch); the matching *_done SHALL be high for exactly the following cycle.
REQ-016 Minimum latency request-to-done SHALL be 3 cycles (latch, bus cycle with ack, done pulse).
REQ-017 mem_re and mem_we SHALL never be high together; both SHALL be 0 in IDLE.
REQ-018 rd_req and wr_req high in the same cycle SHALL be treated as a write and set err.
REQ-019 A new request to a channel whose slot is already occupied SHALL be dropped and set err; the original request SHALL complete unaffected.
REQ-020 A request arriving on the edge its own slot is cleared SHALL be accepted (no err).
REQ-021 ram_data and rom_data SHALL hold their last value until the next completion on that channel.
REQ-022 err SHALL remain set until reset.
REQ-023 busy SHALL be high whenever any slot is occupied or state is not IDLE.

Reset
REQ-024 On reset, state SHALL be IDLE, slots empty, and all outputs (ram_data, rom_data, done pulses, busy, err, mem_*) 0, immediately and independent of clock.
REQ-025 Reset mid-transaction SHALL abandon it with no done pulse after release.

Configuration
REQ-026 Macro MIC1_MEM_TIMEOUT_EN: when defined, an 8-bit counter SHALL run in DATA_RD/DATA_WR/FETCH; on reaching 255 cycles without mem_ack the transaction SHALL complete as if acked with result 32'hDEADBEEF (fetch: 32'h000000EF-style byte per lane) and set err.
REQ-027 Without MIC1_MEM_TIMEOUT_EN, the controller SHALL wait for mem_ack indefinitely and no counter logic SHALL exist.

Verification
REQ-028 rd_req, mar=32'h10, mem_ack one cycle after mem_re, mem_rdata=32'hCAFEBABE -> mem_addr=32'h40, ram_data=32'hCAFEBABE, rd_done 1 cycle, 3 cycles after request.
REQ-029 fetch_req, pc=32'h103, mem_rdata=32'h11223344 -> mem_addr=32'h100, rom_data=32'h00000011, fetch_done pulse.
REQ-030 rd_req and fetch_req same cycle -> data read served first, then fetch; rd_done precedes fetch_done; err=0.
REQ-031 wr_req, mar=32'h2, mdr=32'h55AA55AA, second wr_req while pending -> one mem_we transaction to 32'h8 with 32'h55AA55AA, err=1.
REQ-032 Assert reset while in DATA_RD with mem_ack low -> mem_re=0, busy=0 immediately, no rd_done after release.
REQ-033 With MIC1_MEM_TIMEOUT_EN, rd_req and mem_ack held 0 -> after 255 bus cycles ram_data=32'hDEADBEEF, rd_done pulse, err=1.
